// File: rtl/echo_ranger_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | echo_ranger_ctrl: ultrasonic ranger sequencer that drives TRIGGER, times   |
// | the ECHO pulse and hands results out over valid/ready.                     |
// | Optional macro: ECHO_RANGER_GLITCH_FILTER_EN (3-sample echo majority).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module echo_ranger_ctrl #(
  parameter int TRIG_CYCLES    = 120,
  parameter int TIMEOUT_CYCLES = 360000,
  parameter int HOLDOFF_CYCLES = 240000,
  parameter int CNT_W          = 24
) (
  input  logic             io_mainClk,
  input  logic             io_asyncResetN,
  input  logic             io_enable,
  input  logic             io_start,
  input  logic             io_continuous,
  input  logic             io_echo,
  output logic             io_trigger,
  output logic             io_busy,
  output logic             io_result_valid,
  input  logic             io_result_ready,
  output logic [CNT_W-1:0] io_result_width,
  output logic             io_result_timeout,
  output logic             io_overrun
);

  localparam logic [CNT_W-1:0] c_trig_last = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tmo_last  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_sync;
  logic             r_echo_q;
  logic             w_echo_s;
  logic             w_rise;
  logic             w_pub;
  logic             w_pub_to;
  logic             w_accept;
  logic             r_trigger;
  logic             r_valid;
  logic [CNT_W-1:0] r_width;
  logic             r_timeout;
  logic             r_overrun;

`ifdef ECHO_RANGER_GLITCH_FILTER_EN
  logic [1:0] r_hist;

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) r_hist <= '0;
    else                 r_hist <= {r_hist[0], r_sync[1]};
  end

  assign w_echo_s = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_echo_s = r_sync[1];
`endif

  assign w_rise   = w_echo_s & ~r_echo_q;
  assign w_accept = r_valid & io_result_ready;

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      r_sync   <= '0;
      r_echo_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], io_echo};
      r_echo_q <= w_echo_s;
    end
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_trigger <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_trigger <= (w_state_nxt == S_TRIG);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_pub       = 1'b0;
    w_pub_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (io_start | io_continuous) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (r_cnt == c_trig_last) begin
          w_state_nxt = S_WAIT_RISE;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_RISE: begin
        if (w_rise) begin
          // the rise cycle itself is the first high cycle of the pulse
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_cnt == c_tmo_last) begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = '0;
          w_pub       = 1'b1;
          w_pub_to    = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!w_echo_s) begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = '0;
          w_pub       = 1'b1;
        end else if (r_cnt == c_tmo_last) begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = '0;
          w_pub       = 1'b1;
          w_pub_to    = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == c_hold_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!io_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_pub       = 1'b0;
      w_pub_to    = 1'b0;
    end
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      r_valid   <= 1'b0;
      r_width   <= '0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_pub) begin
        r_valid   <= 1'b1;
        r_width   <= w_pub_to ? {CNT_W{1'b1}} : r_cnt;
        r_timeout <= w_pub_to;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      // a publish coinciding with an accept is a clean handover, not an overrun
      if (w_pub & r_valid & ~io_result_ready) r_overrun <= 1'b1;
      else if (w_accept)                      r_overrun <= 1'b0;
    end
  end

  assign io_trigger        = r_trigger;
  assign io_busy           = (r_state != S_IDLE);
  assign io_result_valid   = r_valid;
  assign io_result_width   = r_width;
  assign io_result_timeout = r_timeout;
  assign io_overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_echo_ranger_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_echo_ranger_ctrl: randomized bench for echo_ranger_ctrl with an         |
// | in-bench phase/elapsed-time model. Honours ECHO_RANGER_GLITCH_FILTER_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_echo_ranger_ctrl;
  localparam int TRIG = 4;
  localparam int TMO  = 100;
  localparam int HOLD = 10;
  localparam int W    = 8;
`ifdef ECHO_RANGER_GLITCH_FILTER_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int P_IDLE = 0, P_TRIG = 1, P_WAIT = 2, P_MEAS = 3, P_HOLD = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic en = 1'b0, start = 1'b0, cont = 1'b0, echo = 1'b0, ready = 1'b0;
  logic trig_o, busy_o, valid_o, to_o, ov_o;
  logic [W-1:0] width_o;

  echo_ranger_ctrl #(.TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD), .CNT_W(W)) dut (
    .io_mainClk(clk), .io_asyncResetN(rst_n), .io_enable(en), .io_start(start),
    .io_continuous(cont), .io_echo(echo), .io_trigger(trig_o), .io_busy(busy_o),
    .io_result_valid(valid_o), .io_result_ready(ready), .io_result_width(width_o),
    .io_result_timeout(to_o), .io_overrun(ov_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0, rand_ready = 0;
  int cap_w, cap_to, trig_hi;

  // model state: phase, cycles spent in phase, echo-high count, pin sample history
  int ph, elapsed, hi;
  bit smp [4];
  bit m_eq, m_trig, m_busy, m_valid, m_to, m_ov;
  int m_w;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int act, input int lo, input int hi_v);
    total++;
    if (act < lo || act > hi_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi_v, $time);
    end
  endtask

  function automatic bit model_echo_s();
`ifdef ECHO_RANGER_GLITCH_FILTER_EN
    return (int'(smp[1]) + int'(smp[2]) + int'(smp[3])) >= 2;
`else
    return smp[1];
`endif
  endfunction

  task automatic model_reset();
    ph = P_IDLE; elapsed = 0; hi = 0;
    foreach (smp[i]) smp[i] = 1'b0;
    m_eq = 0; m_trig = 0; m_busy = 0; m_valid = 0; m_w = 0; m_to = 0; m_ov = 0;
  endtask

  task automatic model_step();
    bit es, rise, pub, pto, acc;
    int nph;
    if (!rst_n) begin model_reset(); return; end
    es = model_echo_s();
    rise = es && !m_eq;
    pub = 0; pto = 0; nph = ph;
    if (en) begin
      case (ph)
        P_IDLE: if (start || cont) nph = P_TRIG;
        P_TRIG: if (elapsed == TRIG - 1) nph = P_WAIT;
        P_WAIT: begin
          if (rise) begin nph = P_MEAS; hi = 1; end
          else if (elapsed == TMO - 1) begin nph = P_HOLD; pub = 1; pto = 1; end
        end
        P_MEAS: begin
          if (!es) begin nph = P_HOLD; pub = 1; end
          else if (hi == TMO - 1) begin nph = P_HOLD; pub = 1; pto = 1; end
          else hi++;
        end
        default: if (elapsed == HOLD - 1) nph = P_IDLE;
      endcase
    end else nph = P_IDLE;
    acc = m_valid && ready;
    if (pub && m_valid && !ready) m_ov = 1;
    else if (acc) m_ov = 0;
    if (pub) begin
      m_valid = 1; m_to = pto; m_w = pto ? (1 << W) - 1 : hi;
    end else if (acc) m_valid = 0;
    elapsed = (nph != ph) ? 0 : elapsed + 1;
    ph = nph;
    m_eq = es;
    smp[3] = smp[2]; smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = echo;
    m_trig = (ph == P_TRIG);
    m_busy = (ph != P_IDLE);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("trigger", int'(trig_o), int'(m_trig));
      check("busy", int'(busy_o), int'(m_busy));
      check("valid", int'(valid_o), int'(m_valid));
      check("width", int'(width_o), m_w);
      check("timeout", int'(to_o), int'(m_to));
      check("overrun", int'(ov_o), int'(m_ov));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (valid_o) begin cap_w = int'(width_o); cap_to = int'(to_o); end
    if (trig_o) trig_hi++;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_trig(input bit level, input int lim);
    int n = 0;
    while (trig_o !== level && n < lim) begin cycle(); n++; end
    if (trig_o !== level) check("wait_trigger", int'(trig_o), int'(level));
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy_o !== 1'b0 && n < lim) begin cycle(); n++; end
    if (busy_o !== 1'b0) check("wait_idle", int'(busy_o), 0);
  endtask

  task automatic shot(input int d, input int w, input bit do_start);
    trig_hi = 0; cap_w = -1; cap_to = -1;
    if (do_start) begin start = 1; cycle(); start = 0; end
    wait_trig(1, 300);
    wait_trig(0, 50);
    repeat (d) cycle();
    if (w > 0) begin echo = 1; repeat (w) cycle(); echo = 0; end
    if (do_start) wait_idle(400);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 0;
    chk_en = 1;
    repeat (3) cycle();
    lit("reset_valid", int'(valid_o), 0, 0);
    lit("reset_width", int'(width_o), 0, 0);
    lit("reset_trigger", int'(trig_o), 0, 0);
    rst_n = 1; en = 1; ready = 1;
    cycle();

    // single shot, 37-cycle echo 20 cycles after trigger
    shot(20, 37, 1);
    lit("shot_trig_len", trig_hi, TRIG, TRIG);
    lit("shot_width", cap_w, 36, 38);
    lit("shot_timeout", cap_to, 0, 0);
    lit("shot_busy", int'(busy_o), 0, 0);

    // no echo at all
    shot(0, 0, 1);
    lit("noecho_width", cap_w, 255, 255);
    lit("noecho_timeout", cap_to, 1, 1);

    // echo stuck high, then a clean 10-cycle pulse
    echo = 1; repeat (5) cycle();
    shot(0, 0, 1);
    lit("stuck_width", cap_w, 255, 255);
    lit("stuck_timeout", cap_to, 1, 1);
    repeat (80) cycle();
    echo = 0; cycle();
    shot(20, 10, 1);
    lit("after_stuck_width", cap_w, 9, 11);

    // continuous mode, consumer stalled for three results
    ready = 0; cont = 1;
    shot(5, 15, 0);
    shot(6, 25, 0);
    shot(7, 35, 0);
    repeat (4) cycle();
    cont = 0;
    wait_idle(400);
    lit("cont_overrun", int'(ov_o), 1, 1);
    lit("cont_width", int'(width_o), 34, 36);
    ready = 1; cycle(); ready = 0;
    lit("cont_valid_cleared", int'(valid_o), 0, 0);
    lit("cont_overrun_cleared", int'(ov_o), 0, 0);

    // publish landing on the same cycle as an accept
    shot(3, 20, 1);
    start = 1; cycle(); start = 0;
    wait_trig(1, 300); wait_trig(0, 50);
    repeat (5) cycle();
    echo = 1; repeat (12) cycle(); echo = 0;
    repeat (2 + EXTRA) cycle();
    ready = 1; cycle(); ready = 0;
    lit("coinc_valid", int'(valid_o), 1, 1);
    lit("coinc_overrun", int'(ov_o), 0, 0);
    lit("coinc_width", int'(width_o), 11, 13);
    wait_idle(400);
    ready = 1; cycle();

    // enable dropped mid-measurement
    start = 1; cycle(); start = 0;
    wait_trig(1, 300); wait_trig(0, 50);
    repeat (3) cycle();
    echo = 1; repeat (10) cycle();
    en = 0; cycle();
    lit("abort_busy", int'(busy_o), 0, 0);
    lit("abort_valid", int'(valid_o), 0, 0);
    echo = 0; en = 1; repeat (3) cycle();

    // asynchronous reset during TRIG
    start = 1; cycle(); start = 0; cycle();
    #2 rst_n = 0; model_reset();
    #1 lit("reset_mid_trig", int'(trig_o), 0, 0);
    repeat (3) cycle();
    rst_n = 1; cycle();

    // single-cycle glitch ahead of a 30-cycle echo
    start = 1; cycle(); start = 0;
    cap_w = -1;
    wait_trig(1, 300); wait_trig(0, 50);
    repeat (5) cycle();
    echo = 1; cycle(); echo = 0; repeat (3) cycle();
    echo = 1; repeat (30) cycle(); echo = 0;
    wait_idle(400);
`ifdef ECHO_RANGER_GLITCH_FILTER_EN
    lit("glitch_width", cap_w, 29, 31);
`else
    lit("glitch_width", cap_w, 1, 1);
`endif

    // randomized shots with a random consumer
    rand_ready = 1;
    for (int i = 0; i < 25; i++) begin
      shot($urandom_range(0, 110), $urandom_range(1, 110), 1);
      if ($urandom_range(0, 5) == 0) begin en = 0; cycle(); en = 1; end
      repeat ($urandom_range(0, 4)) cycle();
    end
    rand_ready = 0; ready = 1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
